// File: rtl/mem_bridge.sv
// Memory-side slave of the core byte bus: sequences one RAM (or I/O page) access per
// request and holds m_wait until data is valid. Optional I/O page: DUST16_MMIO_EN.
module mem_bridge #(
  parameter int                 ADR_TOP     = 15,
  parameter int                 RAM_AW      = 12,
  parameter int                 WAIT_STATES = 0,
  parameter logic [ADR_TOP-8:0] IO_PAGE     = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic              m_wr,
  input  logic [ADR_TOP:0]  m_addr,
  input  logic [7:0]        m_outdata,
  output logic [7:0]        m_indata,
  output logic              m_wait,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        io_out,
  input  logic [7:0]        io_in
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       r_wr, r_io, r_first, r_rvld;
  logic [7:0] r_indata, w_io_rd;
  logic       w_start, w_io_sel;

  assign w_start = (r_state == S_IDLE) && m_req;

`ifdef DUST16_MMIO_EN
  logic [7:0]      r_io_out, r_off;
  logic [1:0][7:0] r_sync;

  assign w_io_sel = (m_addr[ADR_TOP:8] == IO_PAGE);
  assign io_out   = r_io_out;

  always_comb begin
    w_io_rd = 8'h00;
    case (r_off)
      8'h00:   w_io_rd = r_io_out;
      8'h01:   w_io_rd = r_sync[1];
      default: w_io_rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_io_out <= '0;
      r_off    <= '0;
      r_sync   <= '0;
    end else begin
      r_sync <= {r_sync[0], io_in};
      if (w_start) begin
        r_off <= m_addr[7:0];
        if (w_io_sel && m_wr && (m_addr[7:0] == 8'h00)) r_io_out <= m_outdata;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{io_in, m_addr[ADR_TOP:RAM_AW]};
  assign w_io_sel = 1'b0;
  assign w_io_rd  = 8'h00;
  assign io_out   = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start)                                r_cnt <= 4'(WAIT_STATES);
      else if (r_state == S_WAIT && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    m_wait = 1'b0;
    case (r_state)
      S_IDLE: begin
        m_wait = m_req;
        if (m_req) w_next = S_WAIT;
      end
      S_WAIT: begin
        m_wait = 1'b1;
        if (r_cnt == '0) w_next = S_ACK;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RAM read data lands the cycle after ram_en (r_rvld); it is passed straight
  // through that cycle so a zero-wait access still acks with valid data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      r_wr      <= 1'b0;
      r_io      <= 1'b0;
      r_first   <= 1'b0;
      r_rvld    <= 1'b0;
      r_indata  <= '0;
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      r_first <= 1'b0;
      r_rvld  <= ram_en & ~ram_we;
      if (w_start) begin
        ram_en    <= ~w_io_sel;
        ram_we    <= m_wr & ~w_io_sel;
        ram_addr  <= m_addr[RAM_AW-1:0];
        ram_wdata <= m_outdata;
        r_wr      <= m_wr;
        r_io      <= w_io_sel;
        r_first   <= 1'b1;
      end
      if (r_first && r_io && !r_wr) r_indata <= w_io_rd;
      if (r_rvld)                   r_indata <= ram_rdata;
    end
  end

  assign m_indata = r_rvld ? ram_rdata : r_indata;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: two bridges (0 and 3 wait states) each with a behavioural RAM,
// table vectors, hand-written corner sequences and a randomized run against a model.
module tb_mem_bridge;

`ifdef DUST16_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic             clk;
  logic [1:0]       rst_n, req, wr, mwait, en, we;
  logic [1:0][15:0] addr;
  logic [1:0][7:0]  odata, io_in, indata, io_out, wdata;
  logic [1:0][11:0] raddr;

  int checks = 0, failures = 0, cyc = 0, t_start = 0, t_ack = 0;

  logic [7:0] m_mem [2][4096];
  logic [7:0] m_io_out [2];
  logic [7:0] m_io_in [2];
  logic [7:0] last_rd [2];

  for (genvar g = 0; g < 2; g++) begin : g_d
    logic [7:0] mem [4096];
    logic [7:0] rq;
    mem_bridge #(.WAIT_STATES(g == 0 ? 0 : 3)) u_dut (
      .clk(clk), .rst(rst_n[g]), .m_req(req[g]), .m_wr(wr[g]), .m_addr(addr[g]),
      .m_outdata(odata[g]), .m_indata(indata[g]), .m_wait(mwait[g]),
      .ram_en(en[g]), .ram_we(we[g]), .ram_addr(raddr[g]), .ram_wdata(wdata[g]),
      .ram_rdata(rq), .io_out(io_out[g]), .io_in(io_in[g]));
    always_ff @(posedge clk) begin
      if (en[g]) begin
        if (we[g]) mem[raddr[g]] <= wdata[g];
        rq <= mem[raddr[g]];
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Drive one request and observe it until the ack cycle (m_wait low).
  task automatic access(input int k, input bit w, input logic [15:0] a, input logic [7:0] d,
                        input bit keep, output logic [7:0] rd, output int nw,
                        output int nen, output int nwe, output logic [11:0] ea);
    nw = 0; nen = 0; nwe = 0; ea = '0; rd = '0;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; odata[k] = d; t_start = cyc;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (en[k]) begin nen++; ea = raddr[k]; end
      if (we[k]) nwe++;
      if (!mwait[k]) begin rd = indata[k]; t_ack = cyc; break; end
      nw++;
      @(negedge clk);
    end
    if (!keep) begin
      req[k] = 1'b0; wr[k] = 1'($urandom); addr[k] = 16'($urandom); odata[k] = 8'($urandom);
    end
  endtask

  task automatic xact(input int k, input bit w, input logic [15:0] a, input logic [7:0] d,
                      input bit keep, output logic [7:0] rd, output int nw);
    bit io;
    logic [7:0] exp;
    int nen, nwe;
    logic [11:0] ea;
    io = MMIO && (a[15:8] == 8'hFF);
    if (w) begin
      exp = last_rd[k];
      if (io) begin
        if (a[7:0] == 8'h00) m_io_out[k] = d;
      end else m_mem[k][a[11:0]] = d;
    end else begin
      if (!io)                  exp = m_mem[k][a[11:0]];
      else if (a[7:0] == 8'h00) exp = m_io_out[k];
      else if (a[7:0] == 8'h01) exp = m_io_in[k];
      else                      exp = 8'h00;
      last_rd[k] = exp;
    end
    access(k, w, a, d, keep, rd, nw, nen, nwe, ea);
    chk("m_indata", rd, exp);
    chk("wait_cycles", nw, 2 + (k == 0 ? 0 : 3));
    chk("ram_en_pulses", nen, io ? 0 : 1);
    chk("ram_we_pulses", nwe, (!io && w) ? 1 : 0);
    if (!io) chk("ram_addr", ea, a[11:0]);
    chk("io_out", io_out[k], m_io_out[k]);
  endtask

  typedef struct {
    int          k;
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
    int          ew;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [7:0] rd, rd2;
    int nw, t0;
    logic [15:0] ra;

    rst_n = '0; req = '0; wr = '0; addr = '0; odata = '0; io_in = '0;
    for (int k = 0; k < 2; k++) begin
      m_io_out[k] = 8'h00; m_io_in[k] = 8'h00; last_rd[k] = 8'h00;
    end

    tbl[0] = '{0, 1'b1, 16'h0010, 8'hA5, 8'h00, 2};
    tbl[1] = '{0, 1'b0, 16'h0010, 8'h00, 8'hA5, 2};
    tbl[2] = '{0, 1'b1, 16'h0020, 8'h3C, 8'hA5, 2};
    tbl[3] = '{0, 1'b0, 16'h0020, 8'h00, 8'h3C, 2};
    tbl[4] = '{0, 1'b1, 16'h0030, 8'h11, 8'h3C, 2};
    tbl[5] = '{0, 1'b1, 16'h0031, 8'h22, 8'h3C, 2};
    tbl[6] = '{1, 1'b1, 16'h0100, 8'h77, 8'h00, 5};
    tbl[7] = '{1, 1'b0, 16'h1100, 8'h00, 8'h77, 5};
    tbl[8] = '{1, 1'b0, 16'hF100, 8'h00, 8'h77, 5};

    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_m_wait", mwait[k], 0);
      chk("rst_ram_en", en[k], 0);
      chk("rst_ram_we", we[k], 0);
      chk("rst_ram_addr", raddr[k], 0);
      chk("rst_ram_wdata", wdata[k], 0);
      chk("rst_m_indata", indata[k], 0);
      chk("rst_io_out", io_out[k], 0);
    end
    @(negedge clk);
    rst_n = '1;

    // Preload a small window so every later read has a known model value.
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 64; a++) xact(k, 1'b1, 16'(a), 8'($urandom), 1'b0, rd, nw);
    @(negedge clk);
    #1 chk("idle_no_wait", mwait[0], 0);

    for (int i = 0; i < 9; i++) begin
      xact(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, rd, nw);
      chk("tbl_data", rd, tbl[i].exp);
      chk("tbl_wait", nw, tbl[i].ew);
    end

    // m_req held high across two reads
    t0 = 0;
    xact(0, 1'b0, 16'h0030, 8'h00, 1'b1, rd, nw);
    t0 = t_start;
    xact(0, 1'b0, 16'h0031, 8'h00, 1'b0, rd2, nw);
    chk("b2b_first", rd, 8'h11);
    chk("b2b_second", rd2, 8'h22);
    chk("b2b_cycles", t_ack - t0 + 1, 6);

`ifdef DUST16_MMIO_EN
    xact(0, 1'b1, 16'hFF00, 8'h5A, 1'b0, rd, nw);
    chk("mmio_io_out", io_out[0], 8'h5A);
    io_in[0] = 8'h81; m_io_in[0] = 8'h81;
    repeat (3) @(negedge clk);
    xact(0, 1'b0, 16'hFF01, 8'h00, 1'b0, rd, nw);
    chk("mmio_io_in", rd, 8'h81);
    xact(0, 1'b1, 16'hFF05, 8'hEE, 1'b0, rd, nw);
    xact(0, 1'b0, 16'hFF05, 8'h00, 1'b0, rd, nw);
    chk("mmio_other", rd, 8'h00);
    xact(0, 1'b0, 16'hFF00, 8'h00, 1'b0, rd, nw);
    chk("mmio_io_rb", rd, 8'h5A);
`else
    xact(0, 1'b1, 16'hFF00, 8'h5A, 1'b0, rd, nw);
    xact(0, 1'b0, 16'hFF00, 8'h00, 1'b0, rd, nw);
    chk("nommio_ram_rb", rd, 8'h5A);
    chk("nommio_io_out", io_out[0], 8'h00);
`endif

    // Reset before the RAM strobe: the write is dropped
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0012; odata[0] = ~m_mem[0][12'h012];
    #2 rst_n[0] = 1'b0;
    #1 req[0] = 1'b0;
    @(negedge clk);
    #1 chk("discard_ram_en", en[0], 0);
    rst_n[0] = 1'b1;
    m_io_out[0] = 8'h00; last_rd[0] = 8'h00;
    xact(0, 1'b0, 16'h0012, 8'h00, 1'b0, rd, nw);

    // Reset inside S_WAIT
    xact(1, 1'b1, 16'hFF00, 8'hC3, 1'b0, rd, nw);
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0010;
    @(negedge clk);
    #1 chk("pre_rst_ram_en", en[1], 1);
    rst_n[1] = 1'b0; req[1] = 1'b0;
    #1;
    chk("midrst_ram_en", en[1], 0);
    chk("midrst_m_wait", mwait[1], 0);
    chk("midrst_io_out", io_out[1], 0);
    chk("midrst_m_indata", indata[1], 0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    m_io_out[1] = 8'h00; last_rd[1] = 8'h00;
    xact(1, 1'b0, 16'h0010, 8'h00, 1'b0, rd, nw);

    for (int i = 0; i < 120; i++) begin
      if (i % 16 == 0) begin
        for (int k = 0; k < 2; k++) begin
          io_in[k] = 8'($urandom); m_io_in[k] = io_in[k];
        end
        repeat (3) @(negedge clk);
      end
      if (MMIO && ($urandom % 6 == 0)) ra = {8'hFF, 8'($urandom % 3)};
      else ra = {4'($urandom), 6'b0, 6'($urandom)};
      xact(int'($urandom % 2), 1'($urandom), ra, 8'($urandom), 1'b0, rd, nw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
